sevseg_capture: RTL and testbench
=================================

SEVSEG_CAPTURE -- requirements
Module: sevseg_capture

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 16: consecutive stable cycles required before a digit is sampled.
REQ-002 SHALL have input clk, 1 bit: the single clock; all state is clocked on its rising edge.
REQ-003 SHALL have input rst, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have input seg [0:6], 7 bits: active-low segment bus (seg[0]=a ... seg[6]=g), asynchronous to clk.
REQ-005 SHALL have input digit [3:0], 4 bits: active-low anode select, asynchronous to clk.
REQ-006 SHALL have output min [5:0], 6 bits: binary minutes of the last good frame.
REQ-007 SHALL have output sec [5:0], 6 bits: binary seconds of the last good frame.
REQ-008 SHALL have output valid, 1 bit: one-cycle pulse when min/sec update.
REQ-009 SHALL have output err, 1 bit: one-cycle pulse on any capture error.

Function
REQ-010 SHALL pass seg and digit through a 2-flop synchronizer before any use.
REQ-011 SHALL map anode 1110 to sec ones, 1101 to sec tens, 1011 to min ones and 0111 to min tens.
REQ-012 SHALL treat anode 1111 as blank: no sample, no error, frame progress kept.
REQ-013 SHALL treat any anode value with two or more bits low as illegal: err pulse, frame discarded.
REQ-014 SHALL decode seg patterns 0000001, 1001111, 0010010, 0000110, 1001100, 0100100, 0100000, 0001111, 0000000, 0000100 (listed seg[0]..seg[6]) as the values 0 through 9.
REQ-015 SHALL treat any other seg pattern as illegal: err pulse, frame discarded.
REQ-016 SHALL run a per-digit FSM with two states: SETTLE and HOLD.
REQ-017 SETTLE SHALL count the cycles that synchronized {digit,seg} is unchanged and restart the count at 1 on any change.
REQ-018 SHALL take exactly one sample when the SETTLE count reaches SETTLE_CYCLES, then go to HOLD.
REQ-019 HOLD SHALL take no further samples and SHALL return to SETTLE on any change of {digit,seg}.
REQ-020 SHALL record each legal sample as a BCD value plus a bit in a 4-bit seen-mask; a repeated position overwrites its value.
REQ-021 SHALL treat sec tens > 5 as a range error: err pulse, frame discarded.
REQ-022 SHALL treat min tens > 6, or min tens = 6 with min ones > 3, as a range error: err pulse, frame discarded.
REQ-023 When the seen-mask becomes 1111, SHALL set sec = tens*10+ones and min = tens*10+ones, pulse valid, and clear the mask.
REQ-024 valid SHALL assert in the cycle after the fourth sample is registered.
REQ-025 valid and err SHALL never assert in the same cycle; an error on the completing sample gives err only.
REQ-026 On valid, min/sec SHALL update together and SHALL otherwise hold their last values.
REQ-027 Digit order SHALL NOT matter; a frame completes from any sequence that covers all four positions.

Reset
REQ-028 On rst: min=0, sec=0, valid=0, err=0.
REQ-029 On rst: synchronizers load digit=1111 and seg=1111111, the FSM enters SETTLE with count 0, and the mask and BCD store clear.
REQ-030 rst mid-frame SHALL discard partial progress; a full four-digit frame is required after release.

Structure
REQ-031 Package sevseg_pkg SHALL hold the ten segment code constants, the four anode one-hot constants, the digit-position enum and the range limits.
REQ-032 Combinational sub-module sevseg_pattern_decode SHALL map seg to {value[3:0], legal}.

Verification
REQ-033 Frame min tens 1, min ones 2, sec tens 3, sec ones 4, each anode held 100 cycles -> one valid pulse, min=12, sec=34, err=0.
REQ-034 Sec-ones anode held 10 cycles, then blank, then the other three digits -> no valid; after a full 100-cycle hold of sec ones -> valid.
REQ-035 seg=1111111 with anode 1101 for 100 cycles -> err pulse, no valid; next good frame 05:09 -> min=5, sec=9.
REQ-036 Anode 1100 held 100 cycles -> err pulse, mask cleared.
REQ-037 Sec tens=7, other digits legal -> err pulse, min/sec unchanged; min=63, sec=59 frame -> valid with those values.
REQ-038 rst after two digits sampled -> outputs 0; the remaining two digits alone -> no valid.

Source files
------------

// File: rtl/sevseg_pkg.sv
// Shared constants and types for the seven-segment display capture block.
// Segment codes are active-low and listed seg[0] (a) through seg[6] (g).
package sevseg_pkg;

    typedef enum logic [1:0] {
        POS_SEC_ONES = 2'd0,
        POS_SEC_TENS = 2'd1,
        POS_MIN_ONES = 2'd2,
        POS_MIN_TENS = 2'd3
    } digit_pos_e;

    typedef enum logic {
        ST_SETTLE,
        ST_HOLD
    } settle_state_e;

    localparam logic [0:6] SEG_0 = 7'b0000001;
    localparam logic [0:6] SEG_1 = 7'b1001111;
    localparam logic [0:6] SEG_2 = 7'b0010010;
    localparam logic [0:6] SEG_3 = 7'b0000110;
    localparam logic [0:6] SEG_4 = 7'b1001100;
    localparam logic [0:6] SEG_5 = 7'b0100100;
    localparam logic [0:6] SEG_6 = 7'b0100000;
    localparam logic [0:6] SEG_7 = 7'b0001111;
    localparam logic [0:6] SEG_8 = 7'b0000000;
    localparam logic [0:6] SEG_9 = 7'b0000100;

    localparam logic [3:0] ANODE_SEC_ONES = 4'b1110;
    localparam logic [3:0] ANODE_SEC_TENS = 4'b1101;
    localparam logic [3:0] ANODE_MIN_ONES = 4'b1011;
    localparam logic [3:0] ANODE_MIN_TENS = 4'b0111;
    localparam logic [3:0] ANODE_BLANK    = 4'b1111;

    localparam logic [3:0] SEC_TENS_MAX         = 4'd5;
    localparam logic [3:0] MIN_TENS_MAX         = 4'd6;
    localparam logic [3:0] MIN_ONES_AT_TENS_MAX = 4'd3;

    // Only called on range-checked digits, so the result always fits in 6 bits.
    function automatic logic [5:0] bcd_to_bin(input logic [3:0] tens, input logic [3:0] ones);
        logic [5:0] t6;
        logic [5:0] o6;
        t6 = {2'b00, tens};
        o6 = {2'b00, ones};
        return (t6 << 3) + (t6 << 1) + o6;
    endfunction

endpackage

// File: rtl/sevseg_pattern_decode.sv
// Maps an active-low seven-segment pattern to its decimal value.
// Any pattern that is not one of the ten digit shapes is flagged illegal.
module sevseg_pattern_decode
    import sevseg_pkg::*;
(
    input  logic [0:6] seg,
    output logic [3:0] value,
    output logic       legal
);

    always_comb begin
        // NOTE: every output gets a default first so no path through the case can infer a latch.
        value = 4'd0;
        legal = 1'b1;
        case (seg)
            SEG_0:   value = 4'd0;
            SEG_1:   value = 4'd1;
            SEG_2:   value = 4'd2;
            SEG_3:   value = 4'd3;
            SEG_4:   value = 4'd4;
            SEG_5:   value = 4'd5;
            SEG_6:   value = 4'd6;
            SEG_7:   value = 4'd7;
            SEG_8:   value = 4'd8;
            SEG_9:   value = 4'd9;
            default: legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/sevseg_capture.sv
// Samples a multiplexed four-digit MM:SS seven-segment display and reports
// each complete, in-range frame as binary minutes and seconds.
module sevseg_capture
    import sevseg_pkg::*;
#(
    parameter int SETTLE_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [0:6] seg,
    input  logic [3:0] digit,
    output logic [5:0] min,
    output logic [5:0] sec,
    output logic       valid,
    output logic       err
);

    localparam int CW = $clog2(SETTLE_CYCLES + 1);
    localparam logic [CW-1:0] COUNT_DONE = CW'(SETTLE_CYCLES);

    logic [0:6]    seg_meta, seg_sync, seg_prev;
    logic [3:0]    dig_meta, dig_sync, dig_prev;
    settle_state_e state, state_n;
    logic [CW-1:0] count, count_n;
    logic          change, settling, sample;

    logic [3:0]       seg_value;
    logic             seg_legal;
    digit_pos_e       pos;
    logic             one_hot;
    logic [3:0][3:0]  bcd, bcd_n;
    logic [3:0]       mask, mask_n;
    logic [5:0]       min_n, sec_n;
    logic             valid_n, err_n;

    // Synchronizers idle at "blank, all segments off" so reset looks like a dark display.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_meta <= '1;
            seg_sync <= '1;
            seg_prev <= '1;
            dig_meta <= ANODE_BLANK;
            dig_sync <= ANODE_BLANK;
            dig_prev <= ANODE_BLANK;
        end else begin
            // NOTE: non-blocking assignments make each flop take its input's old value, forming a real chain.
            seg_meta <= seg;
            seg_sync <= seg_meta;
            seg_prev <= seg_sync;
            dig_meta <= digit;
            dig_sync <= dig_meta;
            dig_prev <= dig_sync;
        end
    end

    assign change = {dig_sync, seg_sync} != {dig_prev, seg_prev};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_SETTLE;
            count <= '0;
        end else begin
            state <= state_n;
            count <= count_n;
        end
    end

    // A change seen in HOLD restarts settling at 1 in the same cycle as a change in SETTLE.
    always_comb begin
        state_n  = state;
        settling = (state == ST_SETTLE) || change;
        sample   = 1'b0;
        if (change) begin
            count_n = CW'(1);
        end else if (state == ST_SETTLE) begin
            count_n = count + CW'(1);
        end else begin
            count_n = count;
        end
        if (settling) begin
            sample  = (count_n == COUNT_DONE);
            state_n = sample ? ST_HOLD : ST_SETTLE;
        end
    end

    sevseg_pattern_decode u_decode (
        .seg   (seg_sync),
        .value (seg_value),
        .legal (seg_legal)
    );

    always_comb begin
        pos     = POS_SEC_ONES;
        one_hot = 1'b1;
        case (dig_sync)
            ANODE_SEC_ONES: pos = POS_SEC_ONES;
            ANODE_SEC_TENS: pos = POS_SEC_TENS;
            ANODE_MIN_ONES: pos = POS_MIN_ONES;
            ANODE_MIN_TENS: pos = POS_MIN_TENS;
            default:        one_hot = 1'b0;
        endcase
    end

    // Range checks wait for the full frame because the minutes limit depends on both digits.
    always_comb begin
        bcd_n   = bcd;
        mask_n  = mask;
        min_n   = min;
        sec_n   = sec;
        valid_n = 1'b0;
        err_n   = 1'b0;
        if (sample && dig_sync != ANODE_BLANK) begin
            if (!one_hot || !seg_legal) begin
                err_n  = 1'b1;
                mask_n = '0;
            end else begin
                bcd_n[pos]  = seg_value;
                mask_n[pos] = 1'b1;
                if (&mask_n) begin
                    mask_n = '0;
                    if (bcd_n[POS_SEC_TENS] > SEC_TENS_MAX ||
                        bcd_n[POS_MIN_TENS] > MIN_TENS_MAX ||
                        (bcd_n[POS_MIN_TENS] == MIN_TENS_MAX &&
                         bcd_n[POS_MIN_ONES] > MIN_ONES_AT_TENS_MAX)) begin
                        err_n = 1'b1;
                    end else begin
                        valid_n = 1'b1;
                        min_n   = bcd_to_bin(bcd_n[POS_MIN_TENS], bcd_n[POS_MIN_ONES]);
                        sec_n   = bcd_to_bin(bcd_n[POS_SEC_TENS], bcd_n[POS_SEC_ONES]);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the small BCD store is cleared on reset so a stale digit can never leak into a frame.
            bcd   <= '0;
            mask  <= '0;
            min   <= '0;
            sec   <= '0;
            valid <= 1'b0;
            err   <= 1'b0;
        end else begin
            bcd   <= bcd_n;
            mask  <= mask_n;
            min   <= min_n;
            sec   <= sec_n;
            valid <= valid_n;
            err   <= err_n;
        end
    end

endmodule

// File: tb/tb_sevseg_capture.sv
// Directed bench for sevseg_capture: drives display frames and compares
// pulse counts and captured time against hand-computed values.
module tb_sevseg_capture;

    logic       clk = 1'b0;
    logic       rst;
    logic [0:6] seg;
    logic [3:0] digit;
    logic [5:0] min;
    logic [5:0] sec;
    logic       valid;
    logic       err;

    int checks = 0;
    int errors = 0;
    int valid_total = 0;
    int err_total = 0;
    int overlap_total = 0;
    int v0, e0;

    localparam int HOLD = 100;
    localparam int POS_SO = 0, POS_ST = 1, POS_MO = 2, POS_MT = 3;

    // Active-low digit shapes, leftmost bit is segment a.
    localparam logic [6:0] SEGS [10] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
        7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100
    };

    sevseg_capture #(.SETTLE_CYCLES(16)) dut (
        .clk   (clk),
        .rst   (rst),
        .seg   (seg),
        .digit (digit),
        .min   (min),
        .sec   (sec),
        .valid (valid),
        .err   (err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (valid) valid_total <= valid_total + 1;
        if (err) err_total <= err_total + 1;
        if (valid && err) overlap_total <= overlap_total + 1;
    end

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic raw(input logic [3:0] d, input logic [6:0] s, input int n);
        digit = d;
        seg   = s;
        repeat (n) @(negedge clk);
    endtask

    task automatic show(input int pos, input int val, input int n);
        logic [3:0] an;
        an = ~(4'b0001 << pos);
        raw(an, SEGS[val], n);
    endtask

    task automatic blank(input int n);
        raw(4'b1111, 7'b1111111, n);
    endtask

    task automatic mark();
        v0 = valid_total;
        e0 = err_total;
    endtask

    task automatic pulses(input string tag, input int exp_v, input int exp_e);
        check({tag, " valid pulses"}, valid_total - v0, exp_v);
        check({tag, " err pulses"}, err_total - e0, exp_e);
    endtask

    initial begin
        rst   = 1'b1;
        digit = 4'b1111;
        seg   = 7'b1111111;
        repeat (3) @(negedge clk);
        check("reset min", int'(min), 0);
        check("reset sec", int'(sec), 0);
        check("reset valid", int'(valid), 0);
        check("reset err", int'(err), 0);
        rst = 1'b0;
        blank(30);

        // Frame 12:34 shown tens-of-minutes first.
        mark();
        show(POS_MT, 1, HOLD);
        show(POS_MO, 2, HOLD);
        show(POS_ST, 3, HOLD);
        show(POS_SO, 4, HOLD);
        blank(40);
        pulses("frame 12:34", 1, 0);
        check("frame 12:34 min", int'(min), 12);
        check("frame 12:34 sec", int'(sec), 34);

        // A short sec-ones flash must not count as a sample.
        mark();
        show(POS_SO, 5, 10);
        blank(30);
        show(POS_ST, 4, HOLD);
        show(POS_MO, 7, HOLD);
        show(POS_MT, 0, HOLD);
        blank(40);
        pulses("short flash", 0, 0);
        check("short flash min held", int'(min), 12);
        mark();
        show(POS_SO, 5, HOLD);
        blank(40);
        pulses("flash completed", 1, 0);
        check("frame 07:45 min", int'(min), 7);
        check("frame 07:45 sec", int'(sec), 45);

        // Blank segments on a real anode are an illegal pattern.
        mark();
        raw(4'b1101, 7'b1111111, HOLD);
        blank(40);
        pulses("illegal seg", 0, 1);
        check("illegal seg min held", int'(min), 7);
        mark();
        show(POS_SO, 9, HOLD);
        show(POS_MT, 0, HOLD);
        show(POS_ST, 0, HOLD);
        show(POS_MO, 5, HOLD);
        blank(40);
        pulses("frame 05:09", 1, 0);
        check("frame 05:09 min", int'(min), 5);
        check("frame 05:09 sec", int'(sec), 9);

        // Two anodes low discards the two digits already collected.
        mark();
        show(POS_MT, 1, HOLD);
        show(POS_MO, 1, HOLD);
        raw(4'b1100, SEGS[3], HOLD);
        show(POS_ST, 2, HOLD);
        show(POS_SO, 2, HOLD);
        blank(40);
        pulses("two anodes", 0, 1);
        mark();
        show(POS_MT, 1, HOLD);
        show(POS_MO, 1, HOLD);
        blank(40);
        pulses("after two anodes", 1, 0);
        check("frame 11:22 min", int'(min), 11);
        check("frame 11:22 sec", int'(sec), 22);

        // Seconds tens of 7 is out of range.
        mark();
        show(POS_MT, 2, HOLD);
        show(POS_MO, 3, HOLD);
        show(POS_ST, 7, HOLD);
        show(POS_SO, 0, HOLD);
        blank(40);
        pulses("sec tens 7", 0, 1);
        check("sec tens 7 min held", int'(min), 11);
        check("sec tens 7 sec held", int'(sec), 22);

        // 64 minutes is just past the limit.
        mark();
        show(POS_SO, 0, HOLD);
        show(POS_ST, 0, HOLD);
        show(POS_MT, 6, HOLD);
        show(POS_MO, 4, HOLD);
        blank(40);
        pulses("min 64", 0, 1);

        // 63:59 is the largest legal time.
        mark();
        show(POS_ST, 5, HOLD);
        show(POS_MO, 3, HOLD);
        show(POS_SO, 9, HOLD);
        show(POS_MT, 6, HOLD);
        blank(40);
        pulses("frame 63:59", 1, 0);
        check("frame 63:59 min", int'(min), 63);
        check("frame 63:59 sec", int'(sec), 59);

        // Reset mid-frame drops the two digits already sampled.
        show(POS_MT, 4, HOLD);
        show(POS_MO, 2, HOLD);
        blank(5);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("mid reset min", int'(min), 0);
        check("mid reset sec", int'(sec), 0);
        check("mid reset valid", int'(valid), 0);
        check("mid reset err", int'(err), 0);
        rst = 1'b0;
        blank(30);
        mark();
        show(POS_ST, 1, HOLD);
        show(POS_SO, 5, HOLD);
        blank(40);
        pulses("after mid reset", 0, 0);
        check("after mid reset min", int'(min), 0);

        check("valid with err overlap", overlap_total, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
